// File: rtl/axi4r_pkg.sv
// Shared types for the AXI4 read responder: burst encoding, response
// codes and the beat record carried through the R-channel buffer.
package axi4r_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } axi4r_burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic        id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi4r_beat_t;

    // Reserved code 3 and WRAP with an unsupported length both act as INCR.
    function automatic axi4r_burst_e burst_decode(
        input logic [1:0] t,
        input logic [7:0] len
    );
        if (t == 2'd0)
            return BURST_FIXED;
        if (t == 2'd2 &&
            (len == 8'd1 || len == 8'd3 ||
             len == 8'd7 || len == 8'd15))
            return BURST_WRAP;
        return BURST_INCR;
    endfunction

endpackage

// File: rtl/axi4r_rbuf.sv
// Two-entry beat FIFO; the head entry is held in a register.
// Ports: clk, rst_n, push/din in, pop in, dout (head) out, count out.
module axi4r_rbuf
    import axi4r_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  axi4r_beat_t din,
    input  logic        pop,
    output axi4r_beat_t dout,
    output logic [1:0]  count
);

    axi4r_beat_t slot0;
    axi4r_beat_t slot1;

    assign dout = slot0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= '0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (count == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end else begin
                        slot0 <= din;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0)
                        slot0 <= din;
                    else
                        slot1 <= din;
                    count <= count + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axi4r_responder.sv
// AXI4 read responder: one AR burst at a time, beats fetched from a
// synchronous memory port and returned through a 2-entry R buffer.
// Ports: AR channel (arid/araddr/arlen/arburst/arvalid/arready),
// R channel (rid/rdata/rresp/rlast/rvalid/rready),
// memory port (mem_req/mem_addr out, mem_rdata in, one-cycle latency).
// Option: AXI4R_DECERR_EN returns DECERR for indices past the memory.
module axi4r_responder
    import axi4r_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic              rid,
    output logic [63:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [63:0]       mem_rdata
);

    localparam int IW = ADDR_W - 3;

    typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_e;

    state_e       state;
    state_e       state_nx;
    logic         alive;
    logic         arid_q;
    axi4r_burst_e burst_q;
    logic [7:0]   len_q;
    logic [7:0]   beat_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_nx;
    logic [IW-1:0] mask;
    logic         issue;
    logic         last_issue;
    logic         pop;
    logic         oor;
    logic         fl_v;
    logic         fl_id;
    logic         fl_last;
    logic         fl_err;
    logic [1:0]   count;
    logic [2:0]   occ;
    axi4r_beat_t  head;
    axi4r_beat_t  din;
    logic         unused_lsb;

    assign unused_lsb = ^araddr[2:0];

    assign pop        = rvalid & rready;
    assign last_issue = (beat_q == len_q);
    // Entries held after this edge if nothing new is issued.
    assign occ = {1'b0, count} + {2'b0, fl_v} - {2'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (arvalid && arready) state_nx = S_ISSUE;
            S_ISSUE: if (issue && last_issue) state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        arready = alive && (state == S_IDLE);
        issue   = (state == S_ISSUE) && (occ < 3'd2);
    end

    // arready stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            alive <= 1'b0;
        else
            alive <= 1'b1;
    end

    assign mask = IW'(len_q);

    always_comb begin
        idx_nx = idx_q + IW'(1);
        unique case (1'b1)
            burst_q == BURST_FIXED: idx_nx = idx_q;
            burst_q == BURST_WRAP:
                idx_nx = (idx_q & ~mask) | ((idx_q + IW'(1)) & mask);
            default: ;
        endcase
    end

`ifdef AXI4R_DECERR_EN
    assign oor = |idx_q[IW-1:MEM_AW];
`else
    assign oor = 1'b0;
`endif

    assign mem_req  = issue & ~oor;
    assign mem_addr = mem_req ? idx_q[MEM_AW-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arid_q  <= 1'b0;
            burst_q <= BURST_FIXED;
            len_q   <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            fl_v    <= 1'b0;
            fl_id   <= 1'b0;
            fl_last <= 1'b0;
            fl_err  <= 1'b0;
        end else begin
            if (arvalid && arready) begin
                arid_q  <= arid;
                burst_q <= burst_decode(arburst, arlen);
                len_q   <= arlen;
                beat_q  <= '0;
                idx_q   <= araddr[ADDR_W-1:3];
            end else if (issue) begin
                beat_q <= beat_q + 8'd1;
                idx_q  <= idx_nx;
            end
            fl_v    <= issue;
            fl_id   <= arid_q;
            fl_last <= last_issue;
            fl_err  <= oor;
        end
    end

    always_comb begin
        din.id   = fl_id;
        din.data = fl_err ? 64'd0 : mem_rdata;
        din.resp = fl_err ? RESP_DECERR : RESP_OKAY;
        din.last = fl_last;
    end

    axi4r_rbuf u_rbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fl_v),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );

    assign rvalid = (count != 2'd0);
    assign rid    = head.id;
    assign rdata  = head.data;
    assign rresp  = head.resp;
    assign rlast  = head.last & rvalid;

endmodule
